// File: rtl/ram_ctrl.sv
// ram_ctrl: single-port data RAM with valid/ready request and response channels.
// Supports per-byte write strobes, a registered 1-cycle read, an out-of-range error
// flag, and an LED shadow register that holds the inverted low bits of word 0.
// Optional macro RAM_CTRL_INIT_CLEAR_EN: after reset the controller walks the array
// writing zeros (one word per cycle) before it accepts any request.
module ram_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 32,
    parameter int LED_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [DATA_W-1:0]     req_wdata_i,
    input  logic [DATA_W/8-1:0]   req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_W-1:0]     rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [LED_W-1:0]      led_ctl_o
);

    localparam int NB      = DATA_W / 8;
    localparam int BYTE_SH = $clog2(NB);
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WIDX    = ADDR_W - BYTE_SH;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

`ifdef RAM_CTRL_INIT_CLEAR_EN
    localparam state_t RESET_STATE = CLEAR;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    localparam logic [WIDX-1:0]  DEPTH_IDX = WIDX'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

    state_t             state;
    logic [IDX_W-1:0]   clr_cnt;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic [WIDX-1:0]    idx;
    logic [IDX_W-1:0]   widx;
    logic               in_range;
    logic               accept;

    logic               mem_we;
    logic [IDX_W-1:0]   mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [NB-1:0]      mem_be;

    assign idx         = req_addr_i[ADDR_W-1:BYTE_SH];
    assign widx        = idx[IDX_W-1:0];
    assign in_range    = (idx < DEPTH_IDX);
    assign req_ready_o = (state == IDLE) & (~rsp_valid_o | rsp_ready_i);
    assign accept      = req_valid_i & req_ready_o;

    // Byte-offset bits of the address do not select anything inside a word.
    generate
        if (BYTE_SH > 0) begin : g_addr_lsb
            logic unused_addr_lsb;
            assign unused_addr_lsb = ^req_addr_i[BYTE_SH-1:0];
        end
    endgenerate

    // Write port mux: clear walk owns the array in CLEAR, accepted writes otherwise.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = widx;
        mem_wdata = req_wdata_i;
        mem_be    = req_be_i;
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = clr_cnt;
            mem_wdata = '0;
            mem_be    = '1;
        end else if (accept && req_we_i && in_range) begin
            mem_we = 1'b1;
        end
    end

    // Array write with per-byte strobes; contents are not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (mem_be[b]) begin
                    mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Controller FSM with registered response channel and LED shadow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RESET_STATE;
            clr_cnt     <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            led_ctl_o   <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == LAST_IDX) begin
                state     <= IDLE;
                led_ctl_o <= '1;
            end
        end else begin
            if (accept) begin
                rsp_valid_o <= 1'b1;
                rsp_err_o   <= ~in_range;
                if (!req_we_i && in_range) begin
                    rsp_rdata_o <= mem[widx];
                end else begin
                    rsp_rdata_o <= '0;
                end
                if (req_we_i && in_range && (widx == '0) && req_be_i[0]) begin
                    led_ctl_o <= ~req_wdata_i[LED_W-1:0];
                end
            end else if (rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: scoreboard bench for ram_ctrl (DATA_W=32, DEPTH=16, LED_W=4).
// Stimulus pushes the expected {err, rdata} per request; a negedge monitor pops and
// compares whenever a response is consumed, and also checks the 1-cycle latency.
module tb_ram_ctrl;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic [3:0]  req_be_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [3:0]  led_ctl_o;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;
    logic        acc_prev = 1'b0;

    ram_ctrl #(
        .DATA_W(32),
        .DEPTH (DEPTH),
        .ADDR_W(32),
        .LED_W (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_we_i   (req_we_i),
        .req_addr_i (req_addr_i),
        .req_wdata_i(req_wdata_i),
        .req_be_i   (req_be_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o  (rsp_err_o),
        .led_ctl_o  (led_ctl_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: latency check and in-order scoreboard compare on each consumed response.
    always @(negedge clk) begin
        if (acc_prev) chk("rsp_latency", 32'(rsp_valid_o), 32'd1);
        acc_prev = rst_n && req_valid_i && req_ready_o;
        if (rst_n && rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid_o), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata_o, mon_e[31:0]);
                chk("rsp_err", 32'(rsp_err_o), 32'(mon_e[32]));
            end
        end
    end

    // Issue one request; returns 1 time unit after the accepting edge.
    task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_d, input logic exp_e);
        logic rdy;
        rdy = 1'b0;
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_be_i    = be;
        exp_q.push_back({exp_e, exp_d});
        for (int i = 0; i < 64 && !rdy; i++) begin
            @(negedge clk);
            rdy = req_ready_o;
        end
        if (!rdy) begin
            chk("req_ready_timeout", 32'(rdy), 32'd1);
            void'(exp_q.pop_back());
        end else begin
            @(posedge clk);
            #1;
        end
        req_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic count_clear(output int n);
        n = 0;
        @(negedge clk);
        while (!req_ready_o && n < 100) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 32'(rsp_valid_o), 32'd0);
        chk("reset_rdata", rsp_rdata_o, 32'd0);
        chk("reset_err", 32'(rsp_err_o), 32'd0);
        chk("reset_led", 32'(led_ctl_o), 32'd0);

`ifdef RAM_CTRL_INIT_CLEAR_EN
        rst_n = 1'b1;
        count_clear(n);
        chk("clear_cycles", n, 32'd16);
        chk("clear_led", 32'(led_ctl_o), 32'hF);
        // Dirty a word, then interrupt a clear at cycle 8 and require a full restart.
        req(1'b1, 32'h8, 32'h55AA55AA, 4'hF, 32'h0, 1'b0);
        drain();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_clear(n);
        chk("clear_restart_cycles", n, 32'd16);
        chk("clear_restart_led", 32'(led_ctl_o), 32'hF);
        for (int w = 0; w < DEPTH; w++) begin
            req(1'b0, 32'(w * 4), 32'h0, 4'hF, 32'h0, 1'b0);
        end
        drain();
`else
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(req_ready_o), 32'd1);
        @(posedge clk);
        #1;
        chk("idle_led", 32'(led_ctl_o), 32'd0);
`endif

        // Full write then read-after-write.
        req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        req(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);

        // Byte strobes, plus a be=0 no-op write.
        req(1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0);
        req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
        req(1'b0, 32'h20, 32'h0, 4'hF, 32'h11BB33DD, 1'b0);
        req(1'b1, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0);
        req(1'b0, 32'h20, 32'h0, 4'hF, 32'h11BB33DD, 1'b0);

        // LED shadow.
        req(1'b1, 32'h0, 32'h00000005, 4'h1, 32'h0, 1'b0);
        chk("led_word0_write", 32'(led_ctl_o), 32'hA);
        req(1'b1, 32'h0, 32'h12345678, 4'b1110, 32'h0, 1'b0);
        chk("led_no_be0", 32'(led_ctl_o), 32'hA);

        // Out-of-range accesses.
        req(1'b0, 32'(DEPTH * 4), 32'h0, 4'hF, 32'h0, 1'b1);
        req(1'b1, 32'(DEPTH * 4), 32'hCAFEF00D, 4'hF, 32'h0, 1'b1);
        req(1'b0, 32'h0001_0000, 32'h0, 4'hF, 32'h0, 1'b1);
        chk("led_oob_unchanged", 32'(led_ctl_o), 32'hA);
        req(1'b0, 32'h0, 32'h0, 4'hF, 32'h12345605, 1'b0);
        drain();

        // Backpressure hold, same-edge re-accept, then streaming.
        rsp_ready_i = 1'b0;
        req(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = 32'h20;
        req_be_i    = 4'hF;
        exp_q.push_back({1'b0, 32'h11BB33DD});
        repeat (5) begin
            @(negedge clk);
            chk("stall_req_ready", 32'(req_ready_o), 32'd0);
            chk("stall_rsp_valid", 32'(rsp_valid_o), 32'd1);
            chk("stall_rdata", rsp_rdata_o, 32'hDEADBEEF);
        end
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b1;
        @(negedge clk);
        chk("accept_same_edge", 32'(req_ready_o), 32'd1);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        t0 = cyc;
        req(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
        req(1'b0, 32'h20, 32'h0, 4'hF, 32'h11BB33DD, 1'b0);
        req(1'b0, 32'h0, 32'h0, 4'hF, 32'h12345605, 1'b0);
        chk("stream_cycles", 32'(cyc - t0), 32'd3);
        drain();

        // Reset with a response pending drops it.
        rsp_ready_i = 1'b0;
        req(1'b0, 32'h20, 32'h0, 4'hF, 32'h11BB33DD, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_drop_valid", 32'(rsp_valid_o), 32'd0);
        chk("reset_drop_rdata", rsp_rdata_o, 32'd0);
        void'(exp_q.pop_back());
        rst_n = 1'b1;
        rsp_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
